// File: rtl/irq_nest_controller.sv
// Prioritised, nesting interrupt controller for the single-cycle RISC-V core.
// Edge-detects peripheral requests into pending bits. It decides when the core
// redirects to a handler vector, and it keeps the return-address stack that
// uret pops.
//
// Optional feature: define IRQ_AUTO_MASK_EN so that entry also clears ie and
// pushes the previous ie next to the PC. uret then restores that ie.
//
// Ports:
//   clk, rst        clock (rising edge), synchronous active-high reset
//   irq_in          peripheral request levels (already synchronous)
//   cpu_halt        core stalled; blocks interrupt entry
//   pc_next         PC the core would execute next; pushed on entry
//   uret/csrrsi/csrrci, csr_zimm  decoded core ops; zimm[0] is the IE bit
//   irq_take        redirect PC to irq_vector this cycle (combinational)
//   irq_vector      handler address of the winning source (combinational)
//   epc_out         top of the return stack, 0 when empty (combinational)
//   ie              global interrupt enable
//   pending         latched pending requests
//   in_service      sources currently being serviced
//   spurious_uret   sticky: uret seen with an empty stack
module irq_nest_controller #(
  parameter int unsigned          NUM_SRC         = 3,
  parameter int unsigned          ADDR_W          = 32,
  parameter logic [ADDR_W-1:0]    VEC_BASE        = 32'h0000_0400,
  parameter int unsigned          VEC_STRIDE_LOG2 = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_SRC-1:0]  irq_in,
  input  logic                cpu_halt,
  input  logic [ADDR_W-1:0]   pc_next,
  input  logic                uret,
  input  logic                csrrsi,
  input  logic                csrrci,
  input  logic [4:0]          csr_zimm,
  output logic                irq_take,
  output logic [ADDR_W-1:0]   irq_vector,
  output logic [ADDR_W-1:0]   epc_out,
  output logic                ie,
  output logic [NUM_SRC-1:0]  pending,
  output logic [NUM_SRC-1:0]  in_service,
  output logic                spurious_uret
);

  // depth and the priority ceiling both range over 0..NUM_SRC
  localparam int unsigned DEPTH_W = $clog2(NUM_SRC + 1);

  logic [NUM_SRC-1:0] irq_q, pending_q, pending_d, in_service_q, in_service_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic [ADDR_W-1:0]  stack_q [NUM_SRC];
  logic [ADDR_W-1:0]  stack_d [NUM_SRC];
  logic [ADDR_W-1:0]  vec_q, vec_d;
  logic               ie_q, ie_d, spur_q, spur_d;
`ifdef IRQ_AUTO_MASK_EN
  logic [NUM_SRC-1:0] stack_ie_q, stack_ie_d;
  logic               top_ie;
`endif

  logic [NUM_SRC-1:0] edge_det;
  logic [DEPTH_W-1:0] ceiling;
  logic               cand_valid;
  logic [DEPTH_W-1:0] cand_idx;
  logic [NUM_SRC-1:0] cand_oh;
  logic [ADDR_W-1:0]  cand_vec;
  logic [ADDR_W-1:0]  top_pc;
  logic               do_pop;

  // only the IE bit of zimm is architecturally meaningful here
  logic unused_zimm;
  assign unused_zimm = ^csr_zimm[4:1];

  assign edge_det = irq_in & ~irq_q;

  // ceiling = lowest in-service index; candidate = lowest eligible pending index
  always_comb begin
    ceiling    = DEPTH_W'(NUM_SRC);
    cand_valid = 1'b0;
    cand_idx   = '0;
    cand_oh    = '0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (in_service_q[i]) ceiling = DEPTH_W'(i);
    end
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (pending_q[i] && !in_service_q[i] && (DEPTH_W'(i) < ceiling)) begin
        cand_valid = 1'b1;
        cand_idx   = DEPTH_W'(i);
        cand_oh    = NUM_SRC'(1) << i;
      end
    end
    cand_vec = VEC_BASE + (ADDR_W'(cand_idx) << VEC_STRIDE_LOG2);
  end

  // top-of-stack read; an empty stack reads as zero
  always_comb begin
    top_pc = '0;
`ifdef IRQ_AUTO_MASK_EN
    top_ie = 1'b0;
`endif
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (depth_q == DEPTH_W'(i + 1)) begin
        top_pc = stack_q[i];
`ifdef IRQ_AUTO_MASK_EN
        top_ie = stack_ie_q[i];
`endif
      end
    end
  end

  // any decoded uret/csr op defers entry to a later cycle
  assign irq_take   = cand_valid & ie_q & ~cpu_halt & ~uret & ~csrrsi & ~csrrci & ~rst;
  assign irq_vector = cand_valid ? cand_vec : vec_q;
  assign epc_out    = top_pc;
  assign do_pop     = uret & (depth_q != '0);

  // next-state logic
  always_comb begin
    pending_d    = pending_q;
    in_service_d = in_service_q;
    depth_d      = depth_q;
    stack_d      = stack_q;
    ie_d         = ie_q;
    spur_d       = spur_q;
    vec_d        = cand_valid ? cand_vec : vec_q;
`ifdef IRQ_AUTO_MASK_EN
    stack_ie_d   = stack_ie_q;
`endif
    if (irq_take) begin
      for (int i = 0; i < int'(NUM_SRC); i++) begin
        if (depth_q == DEPTH_W'(i)) begin
          stack_d[i] = pc_next;
`ifdef IRQ_AUTO_MASK_EN
          stack_ie_d[i] = ie_q;
`endif
        end
      end
      depth_d      = depth_q + DEPTH_W'(1);
      in_service_d = in_service_q | cand_oh;
      pending_d    = pending_q & ~cand_oh;
`ifdef IRQ_AUTO_MASK_EN
      ie_d         = 1'b0;
`endif
    end else if (do_pop) begin
      depth_d      = depth_q - DEPTH_W'(1);
      // clear the lowest set bit: the most recently entered (highest priority) source
      in_service_d = in_service_q & (in_service_q - NUM_SRC'(1));
`ifdef IRQ_AUTO_MASK_EN
      ie_d         = top_ie;
`endif
    end else if (uret) begin
      spur_d = 1'b1;
    end
    if (csrrsi && csr_zimm[0]) ie_d = 1'b1;
    if (csrrci && csr_zimm[0]) ie_d = 1'b0;
    // a fresh edge wins over the clear on entry
    pending_d = pending_d | edge_det;
  end

  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q        <= '0;
      pending_q    <= '0;
      in_service_q <= '0;
      depth_q      <= '0;
      ie_q         <= 1'b0;
      spur_q       <= 1'b0;
      vec_q        <= VEC_BASE;
      for (int i = 0; i < int'(NUM_SRC); i++) stack_q[i] <= '0;
`ifdef IRQ_AUTO_MASK_EN
      stack_ie_q   <= '0;
`endif
    end else begin
      irq_q        <= irq_in;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      depth_q      <= depth_d;
      ie_q         <= ie_d;
      spur_q       <= spur_d;
      vec_q        <= vec_d;
      for (int i = 0; i < int'(NUM_SRC); i++) stack_q[i] <= stack_d[i];
`ifdef IRQ_AUTO_MASK_EN
      stack_ie_q   <= stack_ie_d;
`endif
    end
  end

  assign ie            = ie_q;
  assign pending       = pending_q;
  assign in_service    = in_service_q;
  assign spurious_uret = spur_q;

endmodule

// File: tb/tb_irq_nest_controller.sv
// Directed, table-driven bench for irq_nest_controller. Each table row is one
// clock cycle: the inputs applied in that cycle, the combinational outputs
// expected in it, and the registered state expected at the start of it.
module tb_irq_nest_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  irq_in;
  logic        cpu_halt;
  logic [31:0] pc_next;
  logic        uret, csrrsi, csrrci;
  logic [4:0]  csr_zimm;
  logic        irq_take;
  logic [31:0] irq_vector, epc_out;
  logic        ie;
  logic [2:0]  pending, in_service;
  logic        spurious_uret;

  int checks   = 0;
  int failures = 0;

  irq_nest_controller dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .cpu_halt(cpu_halt),
    .pc_next(pc_next), .uret(uret), .csrrsi(csrrsi), .csrrci(csrrci),
    .csr_zimm(csr_zimm), .irq_take(irq_take), .irq_vector(irq_vector),
    .epc_out(epc_out), .ie(ie), .pending(pending), .in_service(in_service),
    .spurious_uret(spurious_uret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  irq;
    logic        halt;
    logic [31:0] pc;
    logic        u, si, ci;
    logic [4:0]  z;
    logic        take;
    logic [31:0] vec, epc;
    logic        ie;
    logic [2:0]  pend, insv;
    logic        spur;
  } row_t;

  row_t tbl[$];

  function automatic row_t mk(input logic [2:0] irq, input logic halt, input logic [31:0] pc,
                              input logic u, input logic si, input logic ci, input logic [4:0] z,
                              input logic take, input logic [31:0] vec, input logic [31:0] epc,
                              input logic e, input logic [2:0] pend, input logic [2:0] insv,
                              input logic spur);
    row_t r;
    r.irq = irq; r.halt = halt; r.pc = pc; r.u = u; r.si = si; r.ci = ci; r.z = z;
    r.take = take; r.vec = vec; r.epc = epc; r.ie = e; r.pend = pend; r.insv = insv;
    r.spur = spur;
    return r;
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d actual=0x%0h required=0x%0h", name, row, act, exp);
    end
  endtask

  task automatic drive(input row_t r);
    irq_in = r.irq; cpu_halt = r.halt; pc_next = r.pc;
    uret = r.u; csrrsi = r.si; csrrci = r.ci; csr_zimm = r.z;
  endtask

  task automatic check_row(input int idx, input row_t r);
    chk("irq_take",      idx, 32'(irq_take),      32'(r.take));
    chk("irq_vector",    idx, irq_vector,         r.vec);
    chk("epc_out",       idx, epc_out,            r.epc);
    chk("ie",            idx, 32'(ie),            32'(r.ie));
    chk("pending",       idx, 32'(pending),       32'(r.pend));
    chk("in_service",    idx, 32'(in_service),    32'(r.insv));
    chk("spurious_uret", idx, 32'(spurious_uret), 32'(r.spur));
  endtask

  localparam logic O = 1'b0;
  localparam logic I = 1'b1;

  initial begin
    row_t idle;
    idle = mk(3'b000, O, 32'h0, O, O, O, 5'd0, O, 32'h0, 32'h0, O, 3'b000, 3'b000, O);

    // reset: irq_take forced low, all state cleared
    rst = 1'b1;
    drive(idle);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_take", -1, 32'(irq_take), 32'd0);
    chk("rst_ie",   -1, 32'(ie), 32'd0);
    chk("rst_pend", -1, 32'(pending), 32'd0);
    chk("rst_vec",  -1, irq_vector, 32'h400);
    chk("rst_epc",  -1, epc_out, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

`ifndef IRQ_AUTO_MASK_EN
    //          irq   h  pc        u  si ci z      take vec       epc       ie pend    insv    sp
    tbl.push_back(mk(3'b000,O,32'h000,O,I,O,5'd1,  O,32'h400,32'h000,O,3'b000,3'b000,O)); // 0 csrrsi
    tbl.push_back(mk(3'b000,O,32'h000,O,O,O,5'd0,  O,32'h400,32'h000,I,3'b000,3'b000,O));
    tbl.push_back(mk(3'b100,O,32'h100,O,O,O,5'd0,  O,32'h400,32'h000,I,3'b000,3'b000,O)); // src2 edge
    tbl.push_back(mk(3'b000,O,32'h100,O,O,O,5'd0,  I,32'h420,32'h000,I,3'b100,3'b000,O)); // take src2
    tbl.push_back(mk(3'b000,O,32'h104,O,O,O,5'd0,  O,32'h420,32'h100,I,3'b000,3'b100,O));
    tbl.push_back(mk(3'b001,O,32'h424,O,O,O,5'd0,  O,32'h420,32'h100,I,3'b000,3'b100,O)); // src0 edge
    tbl.push_back(mk(3'b000,O,32'h424,O,O,O,5'd0,  I,32'h400,32'h100,I,3'b001,3'b100,O)); // nest src0
    tbl.push_back(mk(3'b000,O,32'h404,O,O,O,5'd0,  O,32'h400,32'h424,I,3'b000,3'b101,O));
    tbl.push_back(mk(3'b010,O,32'h404,O,O,O,5'd0,  O,32'h400,32'h424,I,3'b000,3'b101,O)); // src1 edge
    tbl.push_back(mk(3'b000,O,32'h404,O,O,O,5'd0,  O,32'h400,32'h424,I,3'b010,3'b101,O)); // blocked
    tbl.push_back(mk(3'b000,O,32'h404,I,O,O,5'd0,  O,32'h400,32'h424,I,3'b010,3'b101,O)); // uret
    tbl.push_back(mk(3'b000,O,32'h424,O,O,O,5'd0,  I,32'h410,32'h100,I,3'b010,3'b100,O)); // take src1
    tbl.push_back(mk(3'b000,O,32'h414,O,O,O,5'd0,  O,32'h410,32'h424,I,3'b000,3'b110,O));
    tbl.push_back(mk(3'b000,O,32'h414,I,O,O,5'd0,  O,32'h410,32'h424,I,3'b000,3'b110,O)); // uret
    tbl.push_back(mk(3'b000,O,32'h424,O,O,O,5'd0,  O,32'h410,32'h100,I,3'b000,3'b100,O));
    tbl.push_back(mk(3'b000,O,32'h424,I,O,O,5'd0,  O,32'h410,32'h100,I,3'b000,3'b100,O)); // uret
    tbl.push_back(mk(3'b000,O,32'h100,O,O,I,5'd1,  O,32'h410,32'h000,I,3'b000,3'b000,O)); // csrrci
    tbl.push_back(mk(3'b010,O,32'h100,O,O,O,5'd0,  O,32'h410,32'h000,O,3'b000,3'b000,O));
    tbl.push_back(mk(3'b000,O,32'h100,O,O,O,5'd0,  O,32'h410,32'h000,O,3'b010,3'b000,O)); // ie=0
    tbl.push_back(mk(3'b000,O,32'h100,O,I,O,5'h1e, O,32'h410,32'h000,O,3'b010,3'b000,O)); // zimm[0]=0
    tbl.push_back(mk(3'b000,O,32'h100,O,I,O,5'd1,  O,32'h410,32'h000,O,3'b010,3'b000,O)); // csrrsi
    tbl.push_back(mk(3'b000,O,32'h200,O,O,O,5'd0,  I,32'h410,32'h000,I,3'b010,3'b000,O)); // take n+1
    tbl.push_back(mk(3'b001,O,32'h204,O,O,O,5'd0,  O,32'h410,32'h200,I,3'b000,3'b010,O)); // src0 edge
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(3'b000,I,32'h204,O,O,O,5'd0,O,32'h400,32'h200,I,3'b001,3'b010,O)); // halted
    tbl.push_back(mk(3'b000,O,32'h300,O,O,O,5'd0,  I,32'h400,32'h200,I,3'b001,3'b010,O)); // take
    tbl.push_back(mk(3'b000,O,32'h404,O,O,O,5'd0,  O,32'h400,32'h300,I,3'b000,3'b011,O));
    tbl.push_back(mk(3'b000,O,32'h404,I,O,O,5'd0,  O,32'h400,32'h300,I,3'b000,3'b011,O)); // uret
    tbl.push_back(mk(3'b000,O,32'h300,I,O,O,5'd0,  O,32'h400,32'h200,I,3'b000,3'b010,O)); // uret
    tbl.push_back(mk(3'b000,O,32'h200,O,O,O,5'd0,  O,32'h400,32'h000,I,3'b000,3'b000,O));
    tbl.push_back(mk(3'b000,O,32'h200,I,O,O,5'd0,  O,32'h400,32'h000,I,3'b000,3'b000,O)); // spurious
    tbl.push_back(mk(3'b010,O,32'h200,O,O,O,5'd0,  O,32'h400,32'h000,I,3'b000,3'b000,I)); // src1 edge
    tbl.push_back(mk(3'b000,O,32'h200,O,I,O,5'd0,  O,32'h410,32'h000,I,3'b010,3'b000,I)); // csr defers
    tbl.push_back(mk(3'b010,O,32'h500,O,O,O,5'd0,  I,32'h410,32'h000,I,3'b010,3'b000,I)); // take+edge
    tbl.push_back(mk(3'b000,O,32'h414,O,O,O,5'd0,  O,32'h410,32'h500,I,3'b010,3'b010,I));
    tbl.push_back(mk(3'b000,O,32'h414,I,O,O,5'd0,  O,32'h410,32'h500,I,3'b010,3'b010,I)); // uret
    tbl.push_back(mk(3'b000,O,32'h600,O,O,O,5'd0,  I,32'h410,32'h000,I,3'b010,3'b000,I)); // re-enter
    tbl.push_back(mk(3'b100,O,32'h414,I,O,O,5'd0,  O,32'h410,32'h600,I,3'b000,3'b010,I)); // uret+edge
    tbl.push_back(mk(3'b000,O,32'h700,O,O,O,5'd0,  I,32'h420,32'h000,I,3'b100,3'b000,I));
    tbl.push_back(mk(3'b000,O,32'h424,O,O,O,5'd0,  O,32'h420,32'h700,I,3'b000,3'b100,I));
`else
    //          irq   h  pc        u  si ci z      take vec       epc       ie pend    insv    sp
    tbl.push_back(mk(3'b000,O,32'h000,O,I,O,5'd1,  O,32'h400,32'h000,O,3'b000,3'b000,O)); // csrrsi
    tbl.push_back(mk(3'b000,O,32'h000,O,O,O,5'd0,  O,32'h400,32'h000,I,3'b000,3'b000,O));
    tbl.push_back(mk(3'b010,O,32'h000,O,O,O,5'd0,  O,32'h400,32'h000,I,3'b000,3'b000,O)); // src1 edge
    tbl.push_back(mk(3'b000,O,32'h100,O,O,O,5'd0,  I,32'h410,32'h000,I,3'b010,3'b000,O)); // take
    tbl.push_back(mk(3'b001,O,32'h414,O,O,O,5'd0,  O,32'h410,32'h100,O,3'b000,3'b010,O)); // masked
    tbl.push_back(mk(3'b000,O,32'h414,O,O,O,5'd0,  O,32'h400,32'h100,O,3'b001,3'b010,O)); // no nest
    tbl.push_back(mk(3'b000,O,32'h414,I,O,O,5'd0,  O,32'h400,32'h100,O,3'b001,3'b010,O)); // uret
    tbl.push_back(mk(3'b000,O,32'h200,O,O,O,5'd0,  I,32'h400,32'h000,I,3'b001,3'b000,O)); // ie back
    tbl.push_back(mk(3'b000,O,32'h404,O,O,O,5'd0,  O,32'h400,32'h200,O,3'b000,3'b001,O));
`endif

    foreach (tbl[k]) begin
      drive(tbl[k]);
      @(negedge clk);
      check_row(k, tbl[k]);
      @(posedge clk); #1;
    end

    // reset while servicing: a live candidate must not be taken during rst
    irq_in = 3'b001; csrrsi = 1'b1; csr_zimm = 5'd1;
    @(posedge clk); #1;
    drive(idle);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_take", -2, 32'(irq_take), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ie",   -3, 32'(ie), 32'd0);
    chk("midrst_pend", -3, 32'(pending), 32'd0);
    chk("midrst_insv", -3, 32'(in_service), 32'd0);
    chk("midrst_epc",  -3, epc_out, 32'h0);
    chk("midrst_vec",  -3, irq_vector, 32'h400);
    chk("midrst_spur", -3, 32'(spurious_uret), 32'd0);
    chk("midrst_take", -3, 32'(irq_take), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
